// File: rtl/mmu_req_arbiter.sv
// Purpose: arbitrates N L1 line-request channels onto the single l1mmu port with a locked, registered grant.
// Latency: request seen in cycle N -> mmu_read/mmu_write in cycle N+1; done is combinational pass-through.
// Backpressure: requesters hold their request until req_done; a one-cycle RELEASE follows every transaction.
//
// Ports:
//   sys_clk, rst_n                 clock, async active-low reset
//   req_read/req_write/req_addr/
//   req_write_data                 per-channel request, packed channel i at [i*W +: W]
//   req_done, req_read_data        one-hot completion pulse and broadcast read line
//   mmu_read/mmu_write/mmu_addr/
//   mmu_write_data                 command to l1mmu
//   mmu_done, mmu_read_data        completion from l1mmu
//   grant_valid, grant_id          in-flight status and granted channel
module mmu_req_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int RR_MODE = 1
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          req_read,
  input  logic [NUM_CH-1:0]          req_write,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*LINE_W-1:0]   req_write_data,
  output logic [NUM_CH-1:0]          req_done,
  output logic [LINE_W-1:0]          req_read_data,
  output logic                       mmu_read,
  output logic                       mmu_write,
  output logic [ADDR_W-1:0]          mmu_addr,
  output logic [LINE_W-1:0]          mmu_write_data,
  input  logic                       mmu_done,
  input  logic [LINE_W-1:0]          mmu_read_data,
  output logic                       grant_valid,
  output logic [$clog2(NUM_CH)-1:0]  grant_id
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     last_grant_q;
  logic [CH_W-1:0]     grant_id_q;
  logic                cmd_read_q, cmd_write_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [NUM_CH-1:0]   cand;
  logic                sel_vld;
  logic [CH_W-1:0]     sel_id;

  assign cand     = req_read | req_write;
  assign grant_id = grant_id_q;

  // Candidate selection. Loops run from the least-preferred position down so
  // the most-preferred candidate is the last assignment to stick.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    if (RR_MODE != 0) begin
      for (int k = NUM_CH; k >= 1; k--) begin
        if (cand[(int'(last_grant_q) + k) % NUM_CH]) begin
          sel_vld = 1'b1;
          sel_id  = CH_W'((int'(last_grant_q) + k) % NUM_CH);
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (cand[i]) begin
          sel_vld = 1'b1;
          sel_id  = CH_W'(i);
        end
      end
    end
  end

  // State register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (sel_vld)  state_d = ST_BUSY;
      ST_BUSY:    if (mmu_done) state_d = ST_RELEASE;
      ST_RELEASE:               state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Grant and command latch. The command is captured once at grant time so the
  // l1mmu sees a stable request even if the requester changes or drops its inputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id_q   <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      cmd_read_q   <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
    end else if (state_q == ST_IDLE && sel_vld) begin
      grant_id_q   <= sel_id;
      last_grant_q <= sel_id;
      cmd_addr_q   <= req_addr[sel_id*ADDR_W +: ADDR_W];
      cmd_write_q  <= req_write[sel_id];
      cmd_read_q   <= req_read[sel_id] & ~req_write[sel_id];
    end
  end

  // Outputs: everything toward l1mmu and the requesters is gated by BUSY
  always_comb begin
    mmu_read       = 1'b0;
    mmu_write      = 1'b0;
    mmu_addr       = '0;
    mmu_write_data = '0;
    grant_valid    = 1'b0;
    req_done       = '0;
    req_read_data  = '0;
    if (state_q == ST_BUSY) begin
      mmu_read       = cmd_read_q;
      mmu_write      = cmd_write_q;
      mmu_addr       = cmd_addr_q;
      mmu_write_data = req_write_data[grant_id_q*LINE_W +: LINE_W];
      grant_valid    = 1'b1;
      if (mmu_done) begin
        req_done      = NUM_CH'(1) << grant_id_q;
        req_read_data = mmu_read_data;
      end
    end
  end

endmodule

// File: doc/mmu_req_arbiter.md
Name: mmu_req_arbiter

Overview:
- Parametrised N-channel arbiter that multiplexes L1 cache line requests (L1I, L1D, future DMA/UART masters) onto the single l1mmu request port.
- Replaces the fixed "I-cache wins" combinational mux in the top level.
- Adds a registered, locked grant, selectable round-robin or fixed-priority policy, a per-transaction command latch, and a release cycle.

Parameters:
- NUM_CH, 2, number of requesting channels (>=2); CH_W = clog2(NUM_CH) is a localparam.
- LINE_W, 256, cache line width in bits.
- ADDR_W, 32, address width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_read  in  NUM_CH  per-channel line read request, held until its req_done
- req_write  in  NUM_CH  per-channel line write request, held until its req_done
- req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies [i*ADDR_W +: ADDR_W]
- req_write_data  in  NUM_CH*LINE_W  per-channel write line, same packing
- req_done  out  NUM_CH  one-hot done pulse to the granted channel
- req_read_data  out  LINE_W  broadcast read line, valid when req_done[i]=1
- mmu_read  out  1  to l1mmu
- mmu_write  out  1  to l1mmu
- mmu_addr  out  ADDR_W  to l1mmu
- mmu_write_data  out  LINE_W  to l1mmu
- mmu_done  in  1  from l1mmu, one-cycle pulse
- mmu_read_data  in  LINE_W  from l1mmu
- grant_valid  out  1  a transaction is in flight (state BUSY)
- grant_id  out  CH_W  index of the granted channel

Behaviour:
- Clock and reset: one clock, sys_clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE; all outputs 0.
  - grant_id = 0.
  - RR pointer last_grant = NUM_CH-1, so channel 0 is searched first.
  - Latched cmd_read/cmd_write/cmd_addr = 0.
- State IDLE:
  - Channel i is a candidate when req_read[i] | req_write[i].
  - RR_MODE=1: select the first candidate searching last_grant+1, last_grant+2, ... modulo NUM_CH.
  - RR_MODE=0: select the lowest-index candidate.
  - If any candidate exists, on the next edge:
    - state -> BUSY; grant_id <= selected channel; last_grant <= selected channel.
    - Latch cmd_addr <= req_addr[sel].
    - Latch cmd_write <= req_write[sel] and cmd_read <= req_read[sel] & ~req_write[sel]; write wins if both are set.
  - With no candidate, state stays IDLE.
  - Latency: request seen in cycle N -> mmu_read/mmu_write high in cycle N+1.
- State BUSY:
  - mmu_read = cmd_read, mmu_write = cmd_write, mmu_addr = cmd_addr (all registered).
  - mmu_write_data = req_write_data[grant_id] (combinational mux; requester holds data stable).
  - grant_valid = 1.
  - Requests from other channels are ignored: the grant is locked.
  - If the granted channel drops its request before done, the latched command is still held until mmu_done.
- Done:
  - On mmu_done=1 in BUSY, in the same cycle (combinational): req_done[grant_id] = 1 and req_read_data = mmu_read_data.
  - On the next edge: state -> RELEASE; mmu_read/mmu_write drop in that cycle.
- State RELEASE:
  - Exactly one cycle; no grant; req_done = 0.
  - Lets the finished requester deassert its request.
  - Next edge -> IDLE.
  - Back-to-back transactions therefore have a 2-cycle gap: done cycle D, RELEASE D+1, IDLE arbitrates D+2, command D+3.
- Outside BUSY: req_read_data = 0 and req_done = 0.
- mmu_done asserted in IDLE or RELEASE is ignored: no req_done, no state change.
- Reset asserted mid-BUSY: all outputs clear asynchronously, the in-flight transaction is abandoned, and the RR pointer returns to NUM_CH-1.
- Fixed-priority mode may starve high-index channels by design; round-robin guarantees service within NUM_CH grants.

Test Plan:
- Single read, NUM_CH=2, RR: req_read[1]=1, addr 0x1000_0040 at cycle 0 -> cycle 1: mmu_read=1, mmu_addr=0x1000_0040, grant_id=1. mmu_done at cycle 4 with data 0xA5..A5 -> req_done=2'b10 and req_read_data=0xA5..A5 in cycle 4; mmu_read=0 in cycle 5; IDLE in cycle 6.
- Round-robin fairness, NUM_CH=3: all three channels request continuously, mmu_done returned 3 cycles after each command -> grant order 0,1,2,0,1,2; no channel granted twice in a row.
- Fixed priority, RR_MODE=0: channels 0 and 2 request together -> grant 0. Channel 0 re-requests in IDLE while 2 still waits -> grant 0 again; channel 2 is granted only once channel 0 stays idle.
- Write path: req_read[0]=1 and req_write[0]=1 with data 0x0123... -> mmu_write=1, mmu_read=0, mmu_write_data equals channel 0 data. Changing req_addr[0] during BUSY does not change mmu_addr.
- Spurious done: mmu_done pulses in IDLE and in RELEASE -> req_done stays 0 and state is unchanged.
- Reset mid-op: rst_n=0 while BUSY on channel 1 -> mmu_read, grant_valid and req_done go to 0 immediately without a clock edge. After rst_n=1 with both channels requesting -> first grant goes to channel 0.
